// File: rtl/stream_gen_t1.sv
// Test-pattern source: a 32-bit incrementing counter sent as 16-bit words,
// high half first. Runs stop only on pair boundaries so the checker sees whole (V, V+1) pairs.
module stream_gen_t1 #(
  parameter logic [31:0] SEED  = 32'h0000_0000,
  parameter int          LEN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] len,
  input  logic             inject_err,
  input  logic             fifo_full,
  output logic [15:0]      data,
  output logic             wren,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] sent_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_HI = 2'd1,
    RUN_LO = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      value_r;
  logic [LEN_W-1:0] sent_cnt_r;
  logic [LEN_W-1:0] target_r;
  logic             stop_pend_r;
  logic             inj_pend_r;
  logic [15:0]      data_r;
  logic             wren_r;
  logic             busy_r;
  logic             done_r;

  logic             emit_hi_s;
  logic             emit_lo_s;
  logic [LEN_W-1:0] sent_next_s;
  logic             end_run_s;

  // Next-state and emission decision for the current cycle.
  always_comb begin
    state_s     = state_r;
    emit_hi_s   = 1'b0;
    emit_lo_s   = 1'b0;
    sent_next_s = sent_cnt_r + CNT_ONE;
    // A target of zero means continuous; a pending stop ends only on an even count.
    end_run_s   = ((target_r != {LEN_W{1'b0}}) && (sent_next_s == target_r)) ||
                  (stop_pend_r && (sent_next_s[0] == 1'b0));
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN_HI;
        end else begin
          state_s = IDLE;
        end
      end
      RUN_HI: begin
        if (!fifo_full) begin
          emit_hi_s = 1'b1;
          state_s   = RUN_LO;
        end else begin
          state_s   = RUN_HI;
        end
      end
      RUN_LO: begin
        if (!fifo_full) begin
          emit_lo_s = 1'b1;
          if (end_run_s) begin
            state_s = FIN;
          end else begin
            state_s = RUN_HI;
          end
        end else begin
          state_s = RUN_LO;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, pending flags and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      value_r     <= SEED;
      sent_cnt_r  <= {LEN_W{1'b0}};
      target_r    <= {LEN_W{1'b0}};
      stop_pend_r <= 1'b0;
      inj_pend_r  <= 1'b0;
      data_r      <= 16'h0000;
      wren_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      wren_r  <= emit_hi_s | emit_lo_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_r == FIN);

      if ((state_r == IDLE) && start) begin
        value_r     <= SEED;
        sent_cnt_r  <= {LEN_W{1'b0}};
        target_r    <= len & ~CNT_ONE;
        stop_pend_r <= 1'b0;
      end else if (emit_lo_s) begin
        value_r    <= value_r + 32'd1;
        sent_cnt_r <= sent_next_s;
      end

      if (((state_r == RUN_HI) || (state_r == RUN_LO)) && stop) begin
        stop_pend_r <= 1'b1;
      end

      // Only the emitted word is corrupted; value_r keeps counting cleanly.
      if (emit_hi_s) begin
        data_r <= value_r[31:16];
      end else if (emit_lo_s) begin
        data_r <= value_r[15:0] ^ {15'd0, inj_pend_r};
      end

      if (emit_lo_s && inj_pend_r) begin
        inj_pend_r <= 1'b0;
      end else if (inject_err) begin
        inj_pend_r <= 1'b1;
      end
    end
  end

  assign data     = data_r;
  assign wren     = wren_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign sent_cnt = sent_cnt_r;

endmodule

// File: tb/tb_stream_gen_t1.sv
// Bench for stream_gen_t1: two instances (SEED 0 and SEED FFFF_FFFF) share the stimulus and
// are compared cycle by cycle against a word-schedule model built from the fifo_full pattern.
module tb_stream_gen_t1;

  localparam int LEN_W = 24;
  localparam int MAXC  = 256;
  localparam int NONE  = -100;
  localparam int RAND  = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] len;
  logic             inject_err;
  logic             fifo_full;
  logic [15:0]      data_a, data_b;
  logic             wren_a, wren_b, busy_a, busy_b, done_a, done_b;
  logic [LEN_W-1:0] sent_a, sent_b;

  int checks = 0;
  int errors = 0;
  bit full_arr [MAXC];

  stream_gen_t1 #(.SEED(32'h0000_0000), .LEN_W(LEN_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len),
    .inject_err(inject_err), .fifo_full(fifo_full),
    .data(data_a), .wren(wren_a), .busy(busy_a), .done(done_a), .sent_cnt(sent_a)
  );

  stream_gen_t1 #(.SEED(32'hFFFF_FFFF), .LEN_W(LEN_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len),
    .inject_err(inject_err), .fifo_full(fifo_full),
    .data(data_b), .wren(wren_b), .busy(busy_b), .done(done_b), .sent_cnt(sent_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " wren_a"}, {31'd0, wren_a}, 32'd0);
    chk({tag, " wren_b"}, {31'd0, wren_b}, 32'd0);
    chk({tag, " busy_a"}, {31'd0, busy_a}, 32'd0);
    chk({tag, " busy_b"}, {31'd0, busy_b}, 32'd0);
    chk({tag, " done_a"}, {31'd0, done_a}, 32'd0);
    chk({tag, " done_b"}, {31'd0, done_b}, 32'd0);
  endtask

  // One run: ln = len, cs = cycle stop is raised (NONE for never), ci = cycle of the
  // inject pulse (-1 = in IDLE before start, NONE, or RAND). Cycle 0 is the start cycle.
  task automatic run(input string name, input int ln, input int cs, input int ci);
    int          e[$];
    int          last = -1;
    int          nv   = 0;
    int          j    = 0;
    int          tgt  = ln & ~1;
    int          iv   = -1;
    int          cinj = ci;
    bit          ew    [MAXC];
    logic [15:0] eda   [MAXC];
    logic [15:0] edb   [MAXC];
    int          esent [MAXC];
    logic [31:0] va, vb;

    // Word j is emitted in the j-th cycle (from cycle 1) with fifo_full low, appearing one cycle later.
    for (int t = 1; (t < MAXC - 8) && (last < 0); t++) begin
      if (!full_arr[t]) begin
        e.push_back(t);
        if (j % 2 == 1) begin
          int v = (j - 1) / 2;
          if (((tgt != 0) && (v + 1 == tgt)) ||
              ((cs >= 1) && ((v + 1) % 2 == 0) && (t >= cs + 1))) begin
            last = t;
            nv   = v + 1;
          end
        end
        j++;
      end
    end
    if (last < 0) begin
      $display("FAIL %s: schedule did not terminate within %0d cycles", name, MAXC);
      errors++;
      return;
    end

    if (cinj == RAND) cinj = $urandom_range(0, e[2*nv-1]) - 1;
    if (cinj != NONE) begin
      for (int v = 0; v < nv; v++) begin
        if ((iv < 0) && (e[2*v+1] >= cinj + 1)) iv = v;
      end
    end

    for (int t = 0; t < MAXC; t++) begin
      ew[t] = 1'b0; eda[t] = 16'h0000; edb[t] = 16'h0000; esent[t] = 0;
    end
    for (int k = 0; k < 2 * nv; k++) begin
      int v = k / 2;
      va = 32'h0000_0000 + v;
      vb = 32'hFFFF_FFFF + v;
      ew[e[k] + 1] = 1'b1;
      if (k % 2 == 0) begin
        eda[e[k] + 1] = va[31:16];
        edb[e[k] + 1] = vb[31:16];
      end else begin
        eda[e[k] + 1] = va[15:0] ^ ((v == iv) ? 16'h0001 : 16'h0000);
        edb[e[k] + 1] = vb[15:0] ^ ((v == iv) ? 16'h0001 : 16'h0000);
        for (int t = e[k] + 1; t < MAXC; t++) esent[t] = v + 1;
      end
    end

    tick();
    inject_err = (cinj == -1);
    tick();
    start      = 1'b1;
    len        = ln[LEN_W-1:0];
    stop       = (cs == 0);
    inject_err = (cinj == 0);
    fifo_full  = full_arr[0];
    for (int t = 1; t <= last + 5; t++) begin
      tick();
      chk($sformatf("%s wren_a c%0d", name, t), {31'd0, wren_a}, {31'd0, ew[t]});
      chk($sformatf("%s wren_b c%0d", name, t), {31'd0, wren_b}, {31'd0, ew[t]});
      if (ew[t]) begin
        chk($sformatf("%s data_a c%0d", name, t), {16'd0, data_a}, {16'd0, eda[t]});
        chk($sformatf("%s data_b c%0d", name, t), {16'd0, data_b}, {16'd0, edb[t]});
      end
      chk($sformatf("%s busy c%0d", name, t), {30'd0, busy_a, busy_b},
          ((t >= 1) && (t <= last + 1)) ? 32'd3 : 32'd0);
      chk($sformatf("%s done c%0d", name, t), {30'd0, done_a, done_b},
          (t == last + 2) ? 32'd3 : 32'd0);
      chk($sformatf("%s sent_a c%0d", name, t), {8'd0, sent_a}, esent[t]);
      chk($sformatf("%s sent_b c%0d", name, t), {8'd0, sent_b}, esent[t]);
      start      = 1'b0;
      stop       = (t == cs);
      inject_err = (t == cinj);
      fifo_full  = full_arr[t];
      len        = LEN_W'($urandom);
    end
    stop = 1'b0; inject_err = 1'b0; fifo_full = 1'b0; len = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; len = '0; inject_err = 1'b0; fifo_full = 1'b0;
    for (int t = 0; t < MAXC; t++) full_arr[t] = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset data_a", {16'd0, data_a}, 32'd0);
    chk("reset data_b", {16'd0, data_b}, 32'd0);
    chk("reset sent_a", {8'd0, sent_a}, 32'd0);
    chk("reset sent_b", {8'd0, sent_b}, 32'd0);
    rst = 1'b0;

    run("len4", 4, NONE, NONE);
    run("len5", 5, NONE, NONE);
    run("len2", 2, NONE, NONE);
    run("cont_stop", 0, 6, NONE);
    run("cont1_stop", 1, 3, NONE);
    run("start_stop_same", 4, 0, NONE);
    run("inject_v1", 4, NONE, 2);
    run("inject_idle", 4, NONE, -1);
    full_arr[4] = 1'b1; full_arr[5] = 1'b1; full_arr[6] = 1'b1;
    run("stall4_6", 2, NONE, NONE);
    for (int t = 0; t < MAXC; t++) full_arr[t] = 1'b0;

    // Abort between the halves of value 0, with an inject pending that reset must clear.
    tick();
    start = 1'b1; len = 24'd4;
    tick();
    start = 1'b0; inject_err = 1'b1;
    tick();
    inject_err = 1'b0;
    chk("pre_rst wren_a", {31'd0, wren_a}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst_mid c3");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_idle_outputs($sformatf("rst_after %0d", k));
    end
    run("restart", 4, NONE, NONE);

    for (int r = 0; r < 25; r++) begin
      int ln = $urandom_range(0, 12);
      int cs;
      int ci;
      for (int t = 0; t < MAXC; t++) full_arr[t] = ($urandom_range(0, 99) < 25);
      if (ln < 2) cs = $urandom_range(1, 30);
      else        cs = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : NONE;
      ci = ($urandom_range(0, 1) == 1) ? RAND : NONE;
      run($sformatf("rnd%0d", r), ln, cs, ci);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
